// File: rtl/sobolflex_sched.sv
// Round-robin scheduler time-sharing one sobolflex core between two Sobol streams.
// Each grant advances exactly one stream by one point; idle cycles freeze the core.
module sobolflex_sched #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic [1:0]          iReq,
    output logic [1:0]          oGnt,
    output logic                oSel,
    output logic [BITWIDTH-1:0] oOneHot,
    output logic                oClr,
    output logic [BITWIDTH-1:0] oCnt,
    output logic [1:0]          oDone
);

    // state  | meaning
    // cnt0/1 | point index n of each stream
    // done   | stream has emitted all 2^BITWIDTH points
    // last   | last granted stream; the other one wins a tie
    // selReg | core select held while idle so oRand stays on that stream
    logic [BITWIDTH-1:0] cnt0;
    logic [BITWIDTH-1:0] cnt1;
    logic [1:0]          done;
    logic                last;
    logic                selReg;

    logic [1:0]          elig;
    logic [1:0]          gnt;
    logic                gntIdx;
    logic [BITWIDTH-1:0] cntG;
    logic [BITWIDTH-1:0] cntInc;

    assign elig = iReq & ~done & {2{~iClr}};

    always_comb begin
        gnt = 2'b00;
        unique case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign gntIdx = gnt[1];
    assign cntG   = gntIdx ? cnt1 : cnt0;
    assign cntInc = cntG + BITWIDTH'(1);

    // All-ones count naturally yields a zero vector: last point shown without a core update.
    assign oGnt    = gnt;
    assign oSel    = (|gnt) ? gntIdx : selReg;
    assign oOneHot = (|gnt) ? (~cntG & cntInc) : '0;
    assign oCnt    = oSel ? cnt1 : cnt0;
    assign oClr    = iClr;
    assign oDone   = done;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt0   <= '0;
            cnt1   <= '0;
            done   <= 2'b00;
            last   <= 1'b1;
            selReg <= 1'b0;
        end else if (iClr) begin
            cnt0 <= '0;
            cnt1 <= '0;
            done <= 2'b00;
            last <= 1'b1;
        end else if (|gnt) begin
            if (gntIdx) begin
                cnt1 <= cntInc;
                if (&cnt1) done[1] <= 1'b1;
            end else begin
                cnt0 <= cntInc;
                if (&cnt0) done[0] <= 1'b1;
            end
            last   <= gntIdx;
            selReg <= gntIdx;
        end
    end

endmodule

// File: tb/tb_sobolflex_sched.sv
// Directed self-checking bench for sobolflex_sched with BITWIDTH=4.
// Inputs change just after the falling edge; Mealy outputs are sampled 1 ns later.
module tb_sobolflex_sched;
    localparam int B = 4;

    logic         iClk = 1'b0;
    logic         iRstN = 1'b0;
    logic         iClr = 1'b0;
    logic [1:0]   iReq = 2'b00;
    logic [1:0]   oGnt;
    logic         oSel;
    logic [B-1:0] oOneHot;
    logic         oClr;
    logic [B-1:0] oCnt;
    logic [1:0]   oDone;

    int checks = 0;
    int failures = 0;

    // Lowest zero bit of n for n = 0..15, worked out by hand.
    logic [B-1:0] ohTab [16] = '{4'd1, 4'd2, 4'd1, 4'd4, 4'd1, 4'd2, 4'd1, 4'd8,
                                 4'd1, 4'd2, 4'd1, 4'd4, 4'd1, 4'd2, 4'd1, 4'd0};

    sobolflex_sched #(.BITWIDTH(B)) dut (
        .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iReq(iReq),
        .oGnt(oGnt), .oSel(oSel), .oOneHot(oOneHot), .oClr(oClr),
        .oCnt(oCnt), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    task automatic test_reset();
        @(negedge iClk);
        iRstN = 1'b1;
        iReq = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (oGnt !== 2'b00 || oOneHot !== 4'd0 || oSel !== 1'b0 || oClr !== 1'b0 ||
                oCnt !== 4'd0 || oDone !== 2'b00) begin
                failures++;
                $display("FAIL reset cyc%0d: gnt=%b oh=%h sel=%b clr=%b cnt=%0d done=%b, want 00/0/0/0/0/00",
                         i, oGnt, oOneHot, oSel, oClr, oCnt, oDone);
            end
            @(negedge iClk);
        end
    endtask

    task automatic test_single_stream();
        iReq = 2'b01;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (oGnt !== 2'b01 || oOneHot !== ohTab[i] || oCnt !== 4'(i) || oSel !== 1'b0 ||
                oDone !== 2'b00) begin
                failures++;
                $display("FAIL single cyc%0d: gnt=%b oh=%h cnt=%0d sel=%b done=%b, want 01/%h/%0d/0/00",
                         i + 1, oGnt, oOneHot, oCnt, oSel, oDone, ohTab[i], i);
            end
            @(negedge iClk);
        end
        #1;
        checks++;
        if (oGnt !== 2'b00 || oOneHot !== 4'd0 || oDone !== 2'b01 || oSel !== 1'b0 || oCnt !== 4'd0) begin
            failures++;
            $display("FAIL single_end: gnt=%b oh=%h done=%b sel=%b cnt=%0d, want 00/0/01/0/0",
                     oGnt, oOneHot, oDone, oSel, oCnt);
        end
        @(negedge iClk);
    endtask

    task automatic test_done_other();
        iReq = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (oGnt !== 2'b10 || oOneHot !== ohTab[i] || oCnt !== 4'(i) || oSel !== 1'b1 ||
                oDone !== 2'b01) begin
                failures++;
                $display("FAIL done_other cyc%0d: gnt=%b oh=%h cnt=%0d sel=%b done=%b, want 10/%h/%0d/1/01",
                         i, oGnt, oOneHot, oCnt, oSel, oDone, ohTab[i], i);
            end
            @(negedge iClk);
        end
    endtask

    task automatic test_clear();
        iReq = 2'b11;
        iClr = 1'b1;
        #1;
        checks++;
        if (oClr !== 1'b1 || oGnt !== 2'b00 || oOneHot !== 4'd0 || oSel !== 1'b1 || oCnt !== 4'd6) begin
            failures++;
            $display("FAIL clear_cycle: clr=%b gnt=%b oh=%h sel=%b cnt=%0d, want 1/00/0/1/6",
                     oClr, oGnt, oOneHot, oSel, oCnt);
        end
        @(negedge iClk);
        iClr = 1'b0;
        #1;
        checks++;
        if (oClr !== 1'b0 || oDone !== 2'b00 || oGnt !== 2'b01 || oCnt !== 4'd0 || oOneHot !== 4'd1 ||
            oSel !== 1'b0) begin
            failures++;
            $display("FAIL clear_after: clr=%b done=%b gnt=%b cnt=%0d oh=%h sel=%b, want 0/00/01/0/1/0",
                     oClr, oDone, oGnt, oCnt, oOneHot, oSel);
        end
        @(negedge iClk);
    endtask

    task automatic test_round_robin();
        iReq = 2'b11;
        iClr = 1'b1;
        @(negedge iClk);
        iClr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (oGnt !== ((k % 2 == 0) ? 2'b01 : 2'b10) || oSel !== 1'(k % 2) ||
                oCnt !== 4'(k / 2) || oOneHot !== ohTab[k / 2] || oDone !== 2'b00) begin
                failures++;
                $display("FAIL round_robin cyc%0d: gnt=%b sel=%b cnt=%0d oh=%h done=%b, want sel=%0d cnt=%0d oh=%h",
                         k, oGnt, oSel, oCnt, oOneHot, oDone, k % 2, k / 2, ohTab[k / 2]);
            end
            @(negedge iClk);
        end
    endtask

    task automatic test_async_reset();
        iReq = 2'b11;
        #3;
        iRstN = 1'b0;
        #1;
        checks++;
        if (oCnt !== 4'd0 || oDone !== 2'b00 || oGnt !== 2'b01 || oSel !== 1'b0 || oOneHot !== 4'd1) begin
            failures++;
            $display("FAIL async_rst_req: cnt=%0d done=%b gnt=%b sel=%b oh=%h, want 0/00/01/0/1",
                     oCnt, oDone, oGnt, oSel, oOneHot);
        end
        iReq = 2'b00;
        #1;
        checks++;
        if (oGnt !== 2'b00 || oOneHot !== 4'd0 || oSel !== 1'b0 || oClr !== 1'b0 || oCnt !== 4'd0) begin
            failures++;
            $display("FAIL async_rst_idle: gnt=%b oh=%h sel=%b clr=%b cnt=%0d, want 00/0/0/0/0",
                     oGnt, oOneHot, oSel, oClr, oCnt);
        end
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
        iReq = 2'b11;
        #1;
        checks++;
        if (oGnt !== 2'b01 || oOneHot !== 4'd1 || oSel !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_first: gnt=%b oh=%h sel=%b, want 01/1/0", oGnt, oOneHot, oSel);
        end
        @(negedge iClk);
        #1;
        checks++;
        if (oGnt !== 2'b10 || oOneHot !== 4'd1 || oSel !== 1'b1 || oCnt !== 4'd0) begin
            failures++;
            $display("FAIL post_rst_second: gnt=%b oh=%h sel=%b cnt=%0d, want 10/1/1/0",
                     oGnt, oOneHot, oSel, oCnt);
        end
        @(negedge iClk);
        iReq = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_done_other();
        test_clear();
        test_round_robin();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
